// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (IFU, LSU) arbiter onto a single memory port.
// One transaction outstanding at a time. LSU has priority, but the IFU is
// forced through after STARVE_MAX contested losses in a row.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  // IFU request / response
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  // LSU request / response
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  // Shared memory port
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int SW     = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_owner_lsu;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic [SW-1:0]       r_starve;

  logic w_idle;
  logic w_starved;
  logic w_grant_ifu;
  logic w_grant_lsu;
  logic w_ifu_ready;
  logic w_lsu_ready;
  logic w_ifu_hs;
  logic w_lsu_hs;
  logic w_owner_resp_ready;
  logic w_resp_hs;

  // Grant is purely combinational in IDLE; rst_n gates it so nothing can be
  // accepted while reset is held.
  assign w_idle      = (r_state == S_IDLE);
  assign w_starved   = (r_starve == STARVE_LIM);
  assign w_grant_ifu = ifu_req_valid & (~lsu_req_valid | w_starved);
  assign w_grant_lsu = lsu_req_valid & ~w_grant_ifu;
  assign w_ifu_ready = w_idle & rst_n & w_grant_ifu;
  assign w_lsu_ready = w_idle & rst_n & w_grant_lsu;
  assign w_ifu_hs    = ifu_req_valid & w_ifu_ready;
  assign w_lsu_hs    = lsu_req_valid & w_lsu_ready;

  assign w_owner_resp_ready = r_owner_lsu ? lsu_resp_ready : ifu_resp_ready;
  assign w_resp_hs = (r_state == S_WAIT) & mem_resp_valid & w_owner_resp_ready;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> ISSUE on grant, ISSUE -> WAIT on request
  // accept, WAIT -> IDLE on response handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_ifu_hs || w_lsu_hs) w_state_next = S_ISSUE;
      S_ISSUE: if (mem_req_ready)        w_state_next = S_WAIT;
      S_WAIT:  if (w_resp_hs)            w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: request fields only visible in ISSUE, response path only
  // routed to the owner in WAIT; everything else is driven to zero.
  always_comb begin
    ifu_req_ready  = w_ifu_ready;
    lsu_req_ready  = w_lsu_ready;
    mem_req_valid  = 1'b0;
    mem_addr       = '0;
    mem_wen        = 1'b0;
    mem_wdata      = '0;
    mem_wmask      = '0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    case (r_state)
      S_ISSUE: begin
        mem_req_valid = 1'b1;
        mem_addr      = r_addr;
        mem_wen       = r_wen;
        mem_wdata     = r_wdata;
        mem_wmask     = r_wmask;
      end
      S_WAIT: begin
        mem_resp_ready = w_owner_resp_ready;
        if (r_owner_lsu) begin
          lsu_resp_valid = mem_resp_valid;
          lsu_rdata      = mem_rdata;
        end else begin
          ifu_resp_valid = mem_resp_valid;
          ifu_rdata      = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // Capture the winning request and track how often a contested IFU lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_lsu <= 1'b0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_starve    <= '0;
    end else if (w_ifu_hs) begin
      r_owner_lsu <= 1'b0;
      r_addr      <= ifu_addr;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_starve    <= '0;
    end else if (w_lsu_hs) begin
      r_owner_lsu <= 1'b1;
      r_addr      <= lsu_addr;
      r_wen       <= lsu_wen;
      r_wdata     <= lsu_wdata;
      r_wmask     <= lsu_wmask;
      if (ifu_req_valid && !w_starved) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; mask width is DATA_W/8.
REQ-003 SHALL have parameter STARVE_MAX, default 3, consecutive contested IFU losses before IFU is forced to win.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports ifu_req_valid in 1, ifu_req_ready out 1, ifu_addr in ADDR_W: IFU read-only request channel.
REQ-007 SHALL have ports ifu_resp_valid out 1, ifu_resp_ready in 1, ifu_rdata out DATA_W: IFU response channel.
REQ-008 SHALL have ports lsu_req_valid in 1, lsu_req_ready out 1, lsu_addr in ADDR_W, lsu_wen in 1, lsu_wdata in DATA_W, lsu_wmask in DATA_W/8: LSU request channel.
REQ-009 SHALL have ports lsu_resp_valid out 1, lsu_resp_ready in 1, lsu_rdata out DATA_W: LSU response channel.
REQ-010 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_addr out ADDR_W, mem_wen out 1, mem_wdata out DATA_W, mem_wmask out DATA_W/8: shared memory request port.
REQ-011 SHALL have ports mem_resp_valid in 1, mem_resp_ready out 1, mem_rdata in DATA_W: shared memory response port.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT; exactly one transaction outstanding at a time.
REQ-013 IDLE: grant computed combinationally; only the winner sees req_ready=1; handshake (valid&ready) latches addr/wen/wdata/wmask and owner, next state ISSUE.
REQ-014 Arbitration: LSU wins when both valid, unless starve counter == STARVE_MAX, then IFU wins.
REQ-015 Starve counter (width clog2(STARVE_MAX+1)): +1 when both valid and LSU wins; cleared when IFU granted; saturates at STARVE_MAX; unchanged otherwise.
REQ-016 IFU requests SHALL be issued with mem_wen=0, mem_wdata=0, mem_wmask=0.
REQ-017 ISSUE: mem_req_valid=1 with latched fields held stable; on mem_req_ready next state WAIT; mem_req_valid never drops before mem_req_ready.
REQ-018 WAIT: mem_resp_ready = owner resp_ready; owner resp_valid = mem_resp_valid; owner rdata = mem_rdata; on mem_resp_valid&mem_resp_ready next state IDLE.
REQ-019 Non-owner resp_valid SHALL be 0 at all times; both req_ready SHALL be 0 outside IDLE; mem_resp_ready SHALL be 0 outside WAIT.
REQ-020 Write transactions SHALL also complete through a response handshake; rdata content is don't-care.
REQ-021 Latency: grant in cycle N -> mem_req_valid in N+1; response handshake in cycle M -> next grant possible in M+1.
REQ-022 mem_resp_valid outside WAIT SHALL be ignored (no state change, not forwarded).
REQ-023 mem_addr/mem_wen/mem_wdata/mem_wmask SHALL be 0 when not in ISSUE.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, starve counter 0, latched fields 0, all valid/ready outputs 0 except IDLE grant logic, which is held off until rst_n=1.
REQ-025 Reset mid-transaction SHALL abandon the transaction with no response delivered; memory-side cleanup is outside this block.

Verification
REQ-026 Only IFU valid, addr 0x80000000, mem_req_ready=1, resp 1 cycle later rdata 0x00000413 -> ifu_resp_valid with rdata 0x00000413, lsu_resp_valid stays 0, 4-cycle round trip.
REQ-027 Both valid, LSU write addr 0x80001000 wdata 0xDEADBEEF wmask 0xF -> LSU granted first, mem_wen=1, fields exact; IFU granted next IDLE.
REQ-028 Both valid continuously, LSU always re-requests -> grant sequence L,L,L,I,L,L,L,I (STARVE_MAX=3).
REQ-029 mem_req_ready low 5 cycles in ISSUE -> mem_req_valid and fields stable all 5 cycles; owner resp_ready low 3 cycles in WAIT -> mem_resp_ready low, state held.
REQ-030 rst_n asserted in WAIT -> outputs 0 same cycle, after release IDLE, spurious mem_resp_valid ignored, new IFU request served normally.
